// File: rtl/lzw_pkg.sv
// Shared definitions for the LZW receive-side backward assembler.
//   - state_e      : assembler FSM state encoding
//   - GMII_*       : preamble / start-of-frame delimiter bytes
//   - LAST_BIT     : position of the end-of-segment flag in a FIFO word
//   - WORD_W       : FIFO word width (flag + byte)
//   - IFG_CNT_W    : width of the saturating inter-frame-gap counter
//   - IFG_LEAD     : cycles from the IDLE start decision to the first byte being
//                    staged, i.e. idle output cycles that are already guaranteed
//                    once IDLE commits to a start
package lzw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StPre,
    StHead,
    StPload,
    StFlush,
    StIfg
  } state_e;

  localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
  localparam logic [7:0]  GMII_SFD      = 8'hD5;

  localparam int unsigned LAST_BIT  = 8;
  localparam int unsigned WORD_W    = 9;

  localparam int unsigned IFG_CNT_W = 5;
  localparam int unsigned IFG_LEAD  = 2;

endpackage

// File: rtl/lzw_ifg_counter.sv
// Saturating idle counter used to enforce the inter-frame gap.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset; counter loads IFG_LEN so the first
//             frame after reset is not held back
//   clear_i : a data byte is being staged for output this cycle
//   ready_o : enough idle cycles have elapsed that a frame may start now
// The count tracks idle cycles on the staged (pre-register) data enable. LEAD
// idle output cycles are still guaranteed after a start decision, so they are
// credited in the compare; this makes the observed gap exactly IFG_LEN.
module lzw_ifg_counter
  import lzw_pkg::*;
#(
  parameter int unsigned IFG_LEN = 12,
  parameter int unsigned LEAD    = IFG_LEAD
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic ready_o
);

  localparam logic [IFG_CNT_W-1:0] CntMax  = '1;
  localparam logic [IFG_CNT_W-1:0] CntInit = IFG_CNT_W'(IFG_LEN);

  logic [IFG_CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= CntInit;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ready_o = ({1'b0, cnt_q} + (IFG_CNT_W + 1)'(LEAD)) >= (IFG_CNT_W + 1)'(IFG_LEN);

endmodule

// File: rtl/lzw_backward_assemble.sv
// Backward assembler: re-serialises a frame's head and payload segments, taken
// from two show-ahead FIFOs with req/ack handshakes, into one GMII byte stream:
// [preamble + SFD] head payload, followed by an enforced inter-frame gap.
//   I_sys_clk / I_sys_rst_n       : clock, asynchronous active-low reset
//   I_head_no_pload               : frame has no payload segment (valid with head req)
//   I_fifo_head_req / _ack        : head segment available / accepted (1-cycle pulse)
//   O_fifo_head_rd, _rdata, _empty: head FIFO pop, show-ahead word {last, byte}, empty
//   I_fifo_pload_req / _ack       : payload segment available / accepted
//   O_fifo_pload_rd, _rdata, _empty: payload FIFO pop, word, empty
//   O_rx_gmii_data / _data_en     : registered GMII output
//   O_underrun_err                : registered 1-cycle pulse when a FIFO runs dry mid-segment
//   O_busy                        : FSM is outside IDLE
module lzw_backward_assemble
  import lzw_pkg::*;
#(
  parameter int unsigned PRE_LEN      = 7,
  parameter bit          ADD_PREAMBLE = 1'b1,
  parameter int unsigned IFG_LEN      = 12
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst_n,
  input  logic              I_head_no_pload,
  input  logic              I_fifo_head_req,
  output logic              O_fifo_head_ack,
  output logic              O_fifo_head_rd,
  input  logic [WORD_W-1:0] I_fifo_head_rdata,
  input  logic              I_fifo_head_empty,
  input  logic              I_fifo_pload_req,
  output logic              O_fifo_pload_ack,
  output logic              O_fifo_pload_rd,
  input  logic [WORD_W-1:0] I_fifo_pload_rdata,
  input  logic              I_fifo_pload_empty,
  output logic [7:0]        O_rx_gmii_data,
  output logic              O_rx_gmii_data_en,
  output logic              O_underrun_err,
  output logic              O_busy
);

  localparam logic [7:0] PreLast = 8'(PRE_LEN);

  state_e     state_d, state_q;
  logic       no_pload_d, no_pload_q;
  logic       flush_head_d, flush_head_q;  // flushing the head FIFO (else payload)
  logic [7:0] pre_cnt_d, pre_cnt_q;
  logic [7:0] data_d, data_q;
  logic       en_d, en_q;
  logic       underrun_d, underrun_q;
  logic       ifg_ready;

  logic head_last, pload_last;
  assign head_last  = I_fifo_head_rdata[LAST_BIT];
  assign pload_last = I_fifo_pload_rdata[LAST_BIT];

  lzw_ifg_counter #(
    .IFG_LEN (IFG_LEN),
    .LEAD    (IFG_LEAD)
  ) u_ifg_counter (
    .clk_i   (I_sys_clk),
    .rst_ni  (I_sys_rst_n),
    .clear_i (en_d),
    .ready_o (ifg_ready)
  );

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q      <= StIdle;
      no_pload_q   <= 1'b0;
      flush_head_q <= 1'b0;
      pre_cnt_q    <= '0;
      data_q       <= '0;
      en_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      no_pload_q   <= no_pload_d;
      flush_head_q <= flush_head_d;
      pre_cnt_q    <= pre_cnt_d;
      data_q       <= data_d;
      en_q         <= en_d;
      underrun_q   <= underrun_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    no_pload_d   = no_pload_q;
    flush_head_d = flush_head_q;
    pre_cnt_d    = pre_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (I_fifo_head_req && (I_head_no_pload || I_fifo_pload_req) && ifg_ready) begin
          state_d    = StAck;
          no_pload_d = I_head_no_pload;
        end
      end
      StAck: begin
        pre_cnt_d = '0;
        state_d   = ADD_PREAMBLE ? StPre : StHead;
      end
      StPre: begin
        if (pre_cnt_q == PreLast) begin
          state_d = StHead;
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      StHead: begin
        if (I_fifo_head_empty) begin
          state_d      = StFlush;
          flush_head_d = 1'b1;
        end else if (head_last) begin
          state_d = no_pload_q ? StIfg : StPload;
        end
      end
      StPload: begin
        if (I_fifo_pload_empty) begin
          state_d      = StFlush;
          flush_head_d = 1'b0;
        end else if (pload_last) begin
          state_d = StIfg;
        end
      end
      StFlush: begin
        // Drain the rest of the truncated segment(s) so the FIFOs stay aligned.
        if (flush_head_q) begin
          if (!I_fifo_head_empty && head_last) begin
            if (no_pload_q) begin
              state_d = StIfg;
            end else begin
              flush_head_d = 1'b0;
            end
          end
        end else if (!I_fifo_pload_empty && pload_last) begin
          state_d = StIfg;
        end
      end
      StIfg:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    O_fifo_head_ack  = (state_q == StAck);
    O_fifo_pload_ack = (state_q == StAck) && !no_pload_q;
    O_fifo_head_rd   = 1'b0;
    O_fifo_pload_rd  = 1'b0;
    data_d           = '0;
    en_d             = 1'b0;
    underrun_d       = 1'b0;
    unique case (state_q)
      StPre: begin
        en_d   = 1'b1;
        data_d = (pre_cnt_q == PreLast) ? GMII_SFD : GMII_PREAMBLE;
      end
      StHead: begin
        if (I_fifo_head_empty) begin
          underrun_d = 1'b1;
        end else begin
          O_fifo_head_rd = 1'b1;
          en_d           = 1'b1;
          data_d         = I_fifo_head_rdata[7:0];
        end
      end
      StPload: begin
        if (I_fifo_pload_empty) begin
          underrun_d = 1'b1;
        end else begin
          O_fifo_pload_rd = 1'b1;
          en_d            = 1'b1;
          data_d          = I_fifo_pload_rdata[7:0];
        end
      end
      StFlush: begin
        if (flush_head_q) begin
          O_fifo_head_rd = !I_fifo_head_empty;
        end else begin
          O_fifo_pload_rd = !I_fifo_pload_empty;
        end
      end
      default: ;
    endcase
  end

  assign O_rx_gmii_data    = data_q;
  assign O_rx_gmii_data_en = en_q;
  assign O_underrun_err    = underrun_q;
  assign O_busy            = (state_q != StIdle);

endmodule

// File: tb/tb_lzw_backward_assemble.sv
// Bench for lzw_backward_assemble. Two instances: default parameters (A) and
// ADD_PREAMBLE=0 (B); `sel` routes the shared FIFO model and observation to one.
module tb_lzw_backward_assemble;

  localparam int PreLen = 7;
  localparam int IfgLen = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic no_pload, head_req, pload_req;
  logic [8:0] h_rdata, p_rdata;
  logic h_empty, p_empty;

  logic hack_a, hrd_a, pack_a, prd_a, en_a, urun_a, busy_a;
  logic hack_b, hrd_b, pack_b, prd_b, en_b, urun_b, busy_b;
  logic [7:0] data_a, data_b;
  logic hack, hrd, pack, prd, en, urun, busy;
  logic [7:0] data;

  always #2 clk = ~clk;

  lzw_backward_assemble dut_a (
    .I_sys_clk          (clk),
    .I_sys_rst_n        (rst_n),
    .I_head_no_pload    (no_pload),
    .I_fifo_head_req    (head_req & ~sel),
    .O_fifo_head_ack    (hack_a),
    .O_fifo_head_rd     (hrd_a),
    .I_fifo_head_rdata  (h_rdata),
    .I_fifo_head_empty  (h_empty | sel),
    .I_fifo_pload_req   (pload_req & ~sel),
    .O_fifo_pload_ack   (pack_a),
    .O_fifo_pload_rd    (prd_a),
    .I_fifo_pload_rdata (p_rdata),
    .I_fifo_pload_empty (p_empty | sel),
    .O_rx_gmii_data     (data_a),
    .O_rx_gmii_data_en  (en_a),
    .O_underrun_err     (urun_a),
    .O_busy             (busy_a)
  );

  lzw_backward_assemble #(
    .ADD_PREAMBLE (1'b0)
  ) dut_b (
    .I_sys_clk          (clk),
    .I_sys_rst_n        (rst_n),
    .I_head_no_pload    (no_pload),
    .I_fifo_head_req    (head_req & sel),
    .O_fifo_head_ack    (hack_b),
    .O_fifo_head_rd     (hrd_b),
    .I_fifo_head_rdata  (h_rdata),
    .I_fifo_head_empty  (h_empty | ~sel),
    .I_fifo_pload_req   (pload_req & sel),
    .O_fifo_pload_ack   (pack_b),
    .O_fifo_pload_rd    (prd_b),
    .I_fifo_pload_rdata (p_rdata),
    .I_fifo_pload_empty (p_empty | ~sel),
    .O_rx_gmii_data     (data_b),
    .O_rx_gmii_data_en  (en_b),
    .O_underrun_err     (urun_b),
    .O_busy             (busy_b)
  );

  assign hack = sel ? hack_b : hack_a;
  assign hrd  = sel ? hrd_b  : hrd_a;
  assign pack = sel ? pack_b : pack_a;
  assign prd  = sel ? prd_b  : prd_a;
  assign en   = sel ? en_b   : en_a;
  assign urun = sel ? urun_b : urun_a;
  assign busy = sel ? busy_b : busy_a;
  assign data = sel ? data_b : data_a;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;

  logic [8:0] hq[$], pq[$];        // FIFO contents, front = show-ahead word
  logic [7:0] hbytes[$], pbytes[$];
  logic [7:0] exp_q[$], got[$];
  int en_cyc[$], hack_cyc[$];
  int pack_n, urun_n, hrd_n, prd_n;
  bit busy_s, auto_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic upd();
    h_empty = (hq.size() == 0);
    h_rdata = h_empty ? 9'h0 : hq[0];
    p_empty = (pq.size() == 0);
    p_rdata = p_empty ? 9'h0 : pq[0];
  endtask

  task automatic clear_mon();
    got.delete(); en_cyc.delete(); hack_cyc.delete();
    pack_n = 0; urun_n = 0; hrd_n = 0; prd_n = 0; busy_s = 1'b1;
  endtask

  // One clock: observe mid-cycle, then apply FIFO pops just after the edge.
  task automatic tick();
    bit hrd_s, prd_s, hack_s;
    @(negedge clk);
    if (en) begin en_cyc.push_back(cyc); got.push_back(data); end
    hack_s = hack;
    if (hack) hack_cyc.push_back(cyc);
    if (pack) pack_n++;
    if (urun) urun_n++;
    hrd_s = hrd; prd_s = prd; busy_s = busy;
    if (hrd_s) hrd_n++;
    if (prd_s) prd_n++;
    @(posedge clk);
    cyc++;
    #1;
    if (hrd_s && hq.size() != 0) void'(hq.pop_front());
    if (prd_s && pq.size() != 0) void'(pq.pop_front());
    if (auto_drop && hack_s) begin head_req = 1'b0; pload_req = 1'b0; end
    upd();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic gen(input int hl, input int pl);
    hbytes.delete(); pbytes.delete();
    for (int i = 0; i < hl; i++) hbytes.push_back(8'($urandom));
    for (int i = 0; i < pl; i++) pbytes.push_back(8'($urandom));
  endtask

  task automatic push_frame(input bit nop);
    foreach (hbytes[i]) hq.push_back({(i == hbytes.size() - 1), hbytes[i]});
    if (!nop) foreach (pbytes[i]) pq.push_back({(i == pbytes.size() - 1), pbytes[i]});
    upd();
  endtask

  // Reference stream: optional preamble+SFD, then head, then payload.
  task automatic build_exp(input bit pre, input bit nop);
    exp_q.delete();
    if (pre) begin
      for (int i = 0; i < PreLen; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
    end
    foreach (hbytes[i]) exp_q.push_back(hbytes[i]);
    if (!nop) foreach (pbytes[i]) exp_q.push_back(pbytes[i]);
  endtask

  task automatic wait_done(input int n_ack, input int budget, input string tag);
    int k = 0;
    while (!(hack_cyc.size() >= n_ack && !busy_s) && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(k >= budget), 0);
  endtask

  task automatic check_bytes(input string tag);
    int n = got.size();
    check({tag, "_len"}, n, exp_q.size());
    if (n > 0) check({tag, "_contig"}, en_cyc[n-1] - en_cyc[0] + 1, n);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic run_frame(input string tag, input bit pre, input bit nop, input bit lat);
    int req_cyc;
    clear_mon();
    push_frame(nop);
    no_pload = nop; head_req = 1'b1; pload_req = !nop; auto_drop = 1'b1;
    req_cyc = cyc;
    wait_done(1, 200, tag);
    build_exp(pre, nop);
    check_bytes(tag);
    check({tag, "_acks"}, hack_cyc.size(), 1);
    check({tag, "_pack"}, pack_n, nop ? 0 : 1);
    check({tag, "_hrd"}, hrd_n, hbytes.size());
    check({tag, "_prd"}, prd_n, nop ? 0 : pbytes.size());
    check({tag, "_urun"}, urun_n, 0);
    if (lat) begin
      check({tag, "_ack_lat"}, hack_cyc.size() > 0 ? hack_cyc[0] - req_cyc : -1, 1);
      check({tag, "_en_lat"}, got.size() > 0 ? en_cyc[0] - req_cyc : -1, 3);
    end
  endtask

  initial begin
    int k, gaps, gap;
    sel = 1'b0; no_pload = 1'b0; head_req = 1'b0; pload_req = 1'b0; auto_drop = 1'b1;
    upd();
    clear_mon();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    idle(3);
    check("rst_en", en, 0);
    check("rst_data", data, 0);
    check("rst_busy", busy, 0);
    check("rst_urun", urun, 0);
    check("rst_acks", {hack, pack}, 0);
    check("rst_rd", {hrd, prd}, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    idle(2);

    // Directed: head A1 A2 A3, payload B1..B4, straight after reset.
    hbytes = '{8'hA1, 8'hA2, 8'hA3};
    pbytes = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    run_frame("basic", 1'b1, 1'b0, 1'b1);

    // No payload: head of 2 bytes only.
    idle(16);
    gen(2, 3);
    run_frame("nopl", 1'b1, 1'b1, 1'b1);

    // Back-to-back frames with requests held: gap must be exactly IfgLen.
    idle(16);
    gen(2, 3);
    clear_mon();
    push_frame(1'b0);
    push_frame(1'b0);
    no_pload = 1'b0; head_req = 1'b1; pload_req = 1'b1; auto_drop = 1'b0;
    k = 0;
    while (hack_cyc.size() < 2 && k < 200) begin tick(); k++; end
    check("b2b_ack_timeout", 32'(k >= 200), 0);
    head_req = 1'b0; pload_req = 1'b0; auto_drop = 1'b1;
    wait_done(2, 200, "b2b");
    build_exp(1'b1, 1'b0);
    k = exp_q.size();
    for (int i = 0; i < k; i++) exp_q.push_back(exp_q[i]);
    check("b2b_len", got.size(), exp_q.size());
    gaps = 0; gap = -1;
    for (int i = 0; i + 1 < en_cyc.size(); i++)
      if (en_cyc[i+1] - en_cyc[i] > 1) begin gaps++; gap = en_cyc[i+1] - en_cyc[i] - 1; end
    check("b2b_breaks", gaps, 1);
    check("b2b_gap", gap, IfgLen);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("b2b_byte%0d", i), got[i], exp_q[i]);

    // Payload underrun after 2 of 5 bytes; the rest arrives 5 cycles later.
    idle(16);
    gen(2, 5);
    clear_mon();
    foreach (hbytes[i]) hq.push_back({(i == hbytes.size() - 1), hbytes[i]});
    pq.push_back({1'b0, pbytes[0]});
    pq.push_back({1'b0, pbytes[1]});
    upd();
    no_pload = 1'b0; head_req = 1'b1; pload_req = 1'b1;
    k = 0;
    while (urun_n == 0 && k < 60) begin tick(); k++; end
    check("urun_timeout", 32'(k >= 60), 0);
    idle(5);
    pq.push_back({1'b0, pbytes[2]});
    pq.push_back({1'b0, pbytes[3]});
    pq.push_back({1'b1, pbytes[4]});
    upd();
    wait_done(1, 100, "urun");
    build_exp(1'b1, 1'b0);
    while (exp_q.size() > PreLen + 1 + 4) void'(exp_q.pop_back());
    check_bytes("urun");
    check("urun_pulses", urun_n, 1);
    check("urun_prd", prd_n, 5);
    check("urun_pq_left", pq.size(), 0);

    // Randomised frames against the reference stream.
    for (int f = 0; f < 4; f++) begin
      int pl;
      idle(16);
      pl = $urandom_range(0, 5);
      gen($urandom_range(1, 4), pl);
      run_frame($sformatf("rnd%0d", f), 1'b1, pl == 0, 1'b1);
    end

    // No-preamble instance: 1-byte head, 1-byte payload.
    sel = 1'b1;
    idle(4);
    hbytes = '{8'h3C};
    pbytes = '{8'hC3};
    run_frame("nopre", 1'b0, 1'b0, 1'b1);
    sel = 1'b0;

    // Reset pulled mid-payload, then a clean frame.
    idle(16);
    gen(2, 6);
    clear_mon();
    push_frame(1'b0);
    no_pload = 1'b0; head_req = 1'b1; pload_req = 1'b1;
    k = 0;
    while (prd_n < 2 && k < 60) begin tick(); k++; end
    check("mrst_timeout", 32'(k >= 60), 0);
    check("mrst_pre_en", en, 1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_en", en, 0);
    check("mrst_data", data, 0);
    check("mrst_busy", busy, 0);
    hq.delete(); pq.delete();
    head_req = 1'b0; pload_req = 1'b0;
    upd();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("mrst_idle", busy, 0);
    gen(3, 2);
    run_frame("mrst_after", 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/lzw_backward_assemble.md
Name: lzw_backward_assemble

Overview:
- Receive-side counterpart of the forward prepare stage.
- Takes a frame's header segment and payload segment from two FWFT FIFOs and uses a req/ack handshake on each.
- Re-serialises them into one GMII byte stream: preamble/SFD, then head, then payload, then the enforced inter-frame gap.
- Sits between the LZW decompress path and the GMII rx output, in the 250 MHz system clock domain.

Parameters:
- PRE_LEN, 7: number of 0x55 preamble bytes before the SFD 0xD5. If ADD_PREAMBLE=0, no preamble or SFD is emitted.
- ADD_PREAMBLE, 1: 1 inserts the preamble and SFD; 0 starts the frame directly with the head bytes.
- IFG_LEN, 12: minimum idle cycles between the last data_en cycle of one frame and the first of the next (range 1..31).

Ports:
- I_sys_clk  in  1  system clock, 250 MHz.
- I_sys_rst_n  in  1  asynchronous, active-low reset.
- I_head_no_pload  in  1  frame has no payload segment; valid while I_fifo_head_req=1.
- I_fifo_head_req  in  1  a complete head segment is present in the head FIFO.
- O_fifo_head_ack  out  1  one-cycle acceptance pulse for the head segment.
- O_fifo_head_rd  out  1  pop strobe for the head FIFO.
- I_fifo_head_rdata  in  9  show-ahead word: [8] = last byte of head, [7:0] = byte.
- I_fifo_head_empty  in  1  head FIFO empty.
- I_fifo_pload_req  in  1  a complete payload segment is present in the payload FIFO.
- O_fifo_pload_ack  out  1  one-cycle acceptance pulse for the payload segment.
- O_fifo_pload_rd  out  1  pop strobe for the payload FIFO.
- I_fifo_pload_rdata  in  9  show-ahead word: [8] = last byte of frame, [7:0] = byte.
- I_fifo_pload_empty  in  1  payload FIFO empty.
- O_rx_gmii_data  out  8  GMII data, registered.
- O_rx_gmii_data_en  out  1  GMII data valid, registered.
- O_underrun_err  out  1  one-cycle pulse when a FIFO runs empty mid-segment.
- O_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM goes to IDLE.
  - The IFG counter loads IFG_LEN, so the first frame after reset can start without waiting for a gap.
- FIFOs are first-word-fall-through: rdata is valid whenever empty=0, and rd=1 pops the word in the same cycle.
- FSM states:
  - IDLE: exits to ACK when I_fifo_head_req=1 and (I_head_no_pload=1 or I_fifo_pload_req=1) and the IFG counter >= IFG_LEN. In that exit cycle it latches no_pload into an internal flag.
  - ACK: asserts O_fifo_head_ack for exactly one cycle. Also asserts O_fifo_pload_ack in the same cycle unless no_pload is latched. Next state is PRE if ADD_PREAMBLE=1, else HEAD.
  - PRE: emits PRE_LEN bytes of 0x55 followed by one byte of 0xD5, one per cycle, with data_en=1. Then goes to HEAD.
  - HEAD: each cycle, if head_empty=0, asserts rd, outputs rdata[7:0] with en=1 on the next cycle. On the cycle that pops a word with rdata[8]=1, goes to IFG if no_pload is latched, else to PLOAD with no gap cycle.
  - PLOAD: same rules as HEAD on the payload FIFO. Popping a word with rdata[8]=1 ends the frame and goes to IFG.
  - IFG: counter is cleared on the last data cycle and increments each cycle while en=0. Returns to IDLE immediately, with the counter saturating at 31.
- Latency: if IDLE decides in cycle N, the acks are high in N+1 and the first byte appears on data_en in N+3.
- Frame length is PRE_LEN+1 (when ADD_PREAMBLE=1) plus head bytes plus payload bytes. data_en stays continuously high from first byte to last byte.
- Underrun: empty=1 in HEAD or PLOAD causes:
  - O_underrun_err pulses once;
  - data_en drops (frame truncated);
  - the FSM moves to a FLUSH state.
- FLUSH: pops the active FIFO whenever it is non-empty until it pops a word with [8]=1, with no output. If the head is flushed and no_pload=0, it then flushes the payload the same way. After that it goes to IFG.
- A head segment of one byte (bit8 set on the first word) is legal. Zero-length payload is signalled only through I_head_no_pload.
- req inputs are ignored outside IDLE. A req that drops before IDLE's decision cycle cancels the start.
- Reset asserted mid-frame: outputs drop to 0 immediately (async). FIFO contents are the upstream owner's responsibility.

Decomposition:
- Shared package lzw_pkg holds:
  - FSM state encoding (IDLE, ACK, PRE, HEAD, PLOAD, FLUSH, IFG);
  - GMII_PREAMBLE=8'h55 and GMII_SFD=8'hD5;
  - the FIFO word layout constants LAST_BIT=8 and WORD_W=9.
- One natural sub-module, lzw_ifg_counter: a saturating idle counter with clear and a ">= IFG_LEN" compare. Everything else stays flat.

Test Plan:
- Head 3 bytes (A1 A2 A3+last) and payload 4 bytes (B1..B4+last), defaults, req at cycle N:
  - acks pulse at N+1;
  - en high for 15 continuous cycles: 55×7, D5, A1 A2 A3, B1 B2 B3 B4.
- I_head_no_pload=1 with head 2 bytes:
  - O_fifo_pload_ack stays 0 and the payload FIFO is not read;
  - 10 en cycles, then IFG.
- Two frames queued back-to-back, IFG_LEN=12: exactly 12 idle cycles between the last en of frame 1 and the first en of frame 2.
- Payload FIFO goes empty after 2 of 5 bytes, with the remaining 3 words written 5 cycles later:
  - O_underrun_err pulses once and en drops after the 2nd payload byte;
  - the 3 late words are popped silently, then IFG.
- ADD_PREAMBLE=0, head 1 byte (last set), payload 1 byte: a 2-cycle frame starting at N+3.
- Reset pulled low mid-PLOAD: en/data go to 0 asynchronously. After release the FSM is in IDLE and the next frame is emitted correctly.
